tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/pong_pkg.sv | 15 +
 rtl/tick_scheduler_strobe_gen.sv | 20 ++
 rtl/tick_scheduler.sv | 67 ++++++
 tb/tb_tick_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared run-state encoding and default divisor constants for the pong timing blocks
package pong_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;
  localparam int CNT_W = 32;
  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_PIX_DIV = 4;
  localparam int DEF_SCAN_DIV = 100_000;
  localparam int DEF_BASE_DIV = 20_000_000;
  localparam int DEF_SEC_DIV = 100_000_000;
  localparam logic [1:0] LVL_MAX = 2'd3;
endpackage

// File: rtl/tick_scheduler_strobe_gen.sv
// strobe_gen: runtime-divisor counter producing a one-cycle clock-enable strobe with hold and clear
module strobe_gen #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic [W-1:0] div,
  input  logic         hold,
  input  logic         clr,
  output logic         strobe
);
  logic [W-1:0] cnt_q, cnt_d;
  logic hit;
  // >= rather than == so a shrinking divisor still fires instead of wrapping
  always_comb begin
    hit = cnt_q >= div - W'(1);
    strobe = hit & ~hold & ~clr;
    cnt_d = clr ? '0 : hold ? cnt_q : hit ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk) cnt_q <= cnt_d;
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: pixel/scan/game/second clock enables plus run FSM and speed level
// Optional second counter enabled by defining TICK_SCHEDULER_SEC_EN.
module tick_scheduler
  import pong_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int BASE_DIV = DEF_BASE_DIV,
  parameter int SEC_DIV  = DEF_SEC_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       speed_up,
  input  logic       speed_clr,
  output logic       pix_en,
  output logic       scan_en,
  output logic       game_tick,
  output logic       sec_tick,
  output logic [1:0] speed_lvl,
  output logic [1:0] state
);
  state_e state_q, state_d;
  logic [1:0] lvl_q, lvl_d;
  logic run_hold, run_clr;
  logic [CNT_W-1:0] game_div;
  if (CLK_HZ < 1 || PIX_DIV < 1 || SCAN_DIV < 1 || BASE_DIV < 8 || SEC_DIV < 1) begin : g_bad_param
    $error("tick_scheduler: divisors must be >= 1 and BASE_DIV >= 8");
  end
  // run counters advance only when RUN now and next, so transition cycles never strobe
  always_comb begin
    state_d = stop ? ST_IDLE
      : (state_q == ST_IDLE && start) ? ST_RUN
      : (state_q == ST_RUN && pause) ? ST_PAUSED
      : (state_q == ST_PAUSED && pause) ? ST_RUN
      : state_q;
    lvl_d = speed_clr ? 2'd0 : (speed_up && lvl_q != LVL_MAX) ? lvl_q + 2'd1 : lvl_q;
    run_clr = rst | (state_d == ST_IDLE);
    run_hold = (state_q != ST_RUN) | (state_d != ST_RUN);
    game_div = CNT_W'(BASE_DIV) >> lvl_q;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? ST_IDLE : state_d;
    lvl_q <= rst ? 2'd0 : lvl_d;
  end
  assign state = state_q;
  assign speed_lvl = lvl_q;
  strobe_gen #(.W(CNT_W)) u_pix (
    .clk(clk), .div(CNT_W'(PIX_DIV)), .hold(1'b0), .clr(rst), .strobe(pix_en)
  );
  strobe_gen #(.W(CNT_W)) u_scan (
    .clk(clk), .div(CNT_W'(SCAN_DIV)), .hold(1'b0), .clr(rst), .strobe(scan_en)
  );
  strobe_gen #(.W(CNT_W)) u_game (
    .clk(clk), .div(game_div), .hold(run_hold), .clr(run_clr), .strobe(game_tick)
  );
`ifdef TICK_SCHEDULER_SEC_EN
  strobe_gen #(.W(CNT_W)) u_sec (
    .clk(clk), .div(CNT_W'(SEC_DIV)), .hold(run_hold), .clr(run_clr), .strobe(sec_tick)
  );
`else
  assign sec_tick = 1'b0;
`endif
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: vector table, directed corner sequences and randomized model check
module tb_tick_scheduler;
  localparam int PIX = 4, SCAN = 6, BASE = 16, SEC = 10;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0, stop = 1'b0, speed_up = 1'b0, speed_clr = 1'b0;
  logic pix_en, scan_en, game_tick, sec_tick;
  logic [1:0] speed_lvl, state;
  int checks = 0, errors = 0;
  typedef struct {
    logic r, s, p, t, u, c;
    int st, lv;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  tick_scheduler #(.PIX_DIV(PIX), .SCAN_DIV(SCAN), .BASE_DIV(BASE), .SEC_DIV(SEC)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .speed_up(speed_up), .speed_clr(speed_clr), .pix_en(pix_en), .scan_en(scan_en),
    .game_tick(game_tick), .sec_tick(sec_tick), .speed_lvl(speed_lvl), .state(state)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_in();
    rst = 0; start = 0; pause = 0; stop = 0; speed_up = 0; speed_clr = 0;
  endtask
  task automatic do_reset();
    clr_in();
    rst = 1;
    cyc();
    rst = 0;
  endtask
  initial begin
    int m_st, m_lvl, m_t, m_g, m_s, ns, nl, gd;
    bit run, eg, es, ep, esc;
    tbl[0]  = '{0,0,0,0,0,0, 0,0};
    tbl[1]  = '{0,0,1,0,0,0, 0,0};
    tbl[2]  = '{0,1,0,0,0,0, 1,0};
    tbl[3]  = '{0,0,1,0,0,0, 2,0};
    tbl[4]  = '{0,1,0,0,0,0, 2,0};
    tbl[5]  = '{0,0,1,0,0,0, 1,0};
    tbl[6]  = '{0,0,0,0,1,0, 1,1};
    tbl[7]  = '{0,0,0,0,1,0, 1,2};
    tbl[8]  = '{0,0,0,0,1,0, 1,3};
    tbl[9]  = '{0,0,0,0,1,0, 1,3};
    tbl[10] = '{0,0,0,0,1,1, 1,0};
    tbl[11] = '{0,1,0,1,0,0, 0,0};
    tbl[12] = '{0,1,1,0,0,0, 1,0};
    tbl[13] = '{0,0,1,1,0,0, 0,0};
    tbl[14] = '{0,0,0,0,1,0, 0,1};
    tbl[15] = '{1,1,0,0,1,0, 0,0};
    repeat (2) cyc();
    do_reset();
    chk("reset_state", state, 0);
    chk("reset_lvl", speed_lvl, 0);
    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].s; pause = tbl[i].p;
      stop = tbl[i].t; speed_up = tbl[i].u; speed_clr = tbl[i].c;
      cyc();
      clr_in();
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_lvl", i), speed_lvl, tbl[i].lv);
    end
    // pix/scan cadence right after reset release
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("pix_c%0d", c), pix_en, (c % PIX) == 0);
      chk($sformatf("scan_c%0d", c), scan_en, (c % SCAN) == 0);
      cyc();
    end
    // level 0 cadence, then two speed_up pulses
    do_reset();
    start = 1; cyc(); start = 0;
    for (int r = 1; r <= 48; r++) begin
      @(negedge clk);
      chk($sformatf("lvl0_tick_r%0d", r), game_tick, (r % 16) == 0);
      cyc();
    end
    speed_up = 1; cyc(); cyc(); speed_up = 0;
    chk("lvl2_after_two_up", speed_lvl, 2);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      chk($sformatf("lvl2_tick_r%0d", r), game_tick, (r % 4) == 1);
      cyc();
    end
    // pause at count 5, hold 10 cycles, resume
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    pause = 1;
    @(negedge clk);
    chk("pause_enter_tick", game_tick, 0);
    cyc(); pause = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk($sformatf("paused%0d_state", j), state, 2);
      chk($sformatf("paused%0d_tick", j), game_tick, 0);
      cyc();
    end
    pause = 1;
    @(negedge clk);
    chk("pause_exit_tick", game_tick, 0);
    cyc(); pause = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("resume_tick_k%0d", k), game_tick, k == 11);
      cyc();
    end
    // stop+pause on the would-be tick cycle
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (15) cyc();
    stop = 1; pause = 1;
    @(negedge clk);
    chk("stop_cycle_tick", game_tick, 0);
    cyc(); clr_in();
    chk("stop_state", state, 0);
    chk("stop_tick", game_tick, 0);
    start = 1; cyc(); start = 0;
    for (int r = 1; r <= 16; r++) begin
      @(negedge clk);
      chk($sformatf("restart_tick_r%0d", r), game_tick, r == 16);
      cyc();
    end
    // reset at count 7 with competing inputs
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (7) cyc();
    rst = 1; speed_up = 1; start = 1;
    @(negedge clk);
    chk("rst_cycle_tick", game_tick, 0);
    chk("rst_cycle_pix", pix_en, 0);
    cyc(); clr_in();
    @(negedge clk);
    chk("post_rst_state", state, 0);
    chk("post_rst_lvl", speed_lvl, 0);
    chk("post_rst_tick", game_tick, 0);
    chk("post_rst_pix", pix_en, 0);
    chk("post_rst_scan", scan_en, 0);
    chk("post_rst_sec", sec_tick, 0);
    cyc();
    // randomized run against a cycle-count model
    do_reset();
    m_st = 0; m_lvl = 0; m_t = 1; m_g = 0; m_s = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(499) == 0);
      start = ($urandom_range(7) == 0);
      pause = ($urandom_range(15) == 0);
      stop = ($urandom_range(63) == 0);
      speed_up = ($urandom_range(31) == 0);
      speed_clr = ($urandom_range(63) == 0);
      @(negedge clk);
      ns = stop ? 0 : (m_st == 0 && start) ? 1 : (m_st == 1 && pause) ? 2 : (m_st == 2 && pause) ? 1 : m_st;
      nl = speed_clr ? 0 : speed_up ? (m_lvl == 3 ? 3 : m_lvl + 1) : m_lvl;
      run = !rst && m_st == 1 && ns == 1;
      gd = BASE / (1 << m_lvl);
      eg = run && (m_g + 1 >= gd);
`ifdef TICK_SCHEDULER_SEC_EN
      es = run && (m_s + 1 >= SEC);
`else
      es = 0;
`endif
      ep = !rst && (m_t % PIX == 0);
      esc = !rst && (m_t % SCAN == 0);
      chk("rnd_state", state, m_st);
      chk("rnd_lvl", speed_lvl, m_lvl);
      chk("rnd_pix", pix_en, ep);
      chk("rnd_scan", scan_en, esc);
      chk("rnd_game", game_tick, eg);
      chk("rnd_sec", sec_tick, es);
      if (rst) begin
        m_st = 0; m_lvl = 0; m_t = 1; m_g = 0; m_s = 0;
      end else begin
        m_g = (ns == 0) ? 0 : run ? (eg ? 0 : m_g + 1) : m_g;
        m_s = (ns == 0) ? 0 : run ? (es ? 0 : m_s + 1) : m_s;
        m_st = ns; m_lvl = nl; m_t++;
      end
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
